// File: rtl/port_lane_serializer_pkg.sv
// Shared types and helpers for the lane serializer: FSM state, index sizing
// and the lane extension rule.
package port_lane_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned EXT_W = 64;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Lane arrives zero-padded to EXT_W; caller truncates the result to its output width.
    function automatic logic [EXT_W-1:0] lane_ext(input logic [EXT_W-1:0] lane,
                                                  input int unsigned       lane_w,
                                                  input logic              signed_en);
        logic [EXT_W-1:0] keep;
        logic [5:0]       top;
        keep = (lane_w >= EXT_W) ? '1 : ((EXT_W'(1) << lane_w) - EXT_W'(1));
        top  = 6'(lane_w - 1);
        if (signed_en && lane[top]) begin
            return lane | ~keep;
        end
        return lane & keep;
    endfunction

endpackage

// File: rtl/port_lane_serializer_lane_extract.sv
// Combinational lane select plus sign/zero extension; registered by the parent.
module lane_extract
    import port_lane_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int LANE_W = 4,
    parameter int OUT_W  = 8,
    parameter int SIGNED = 0,
    parameter int IDX_W  = 1
) (
    input  logic [IN_W-1:0]  word,
    input  logic [IDX_W-1:0] lane_sel,
    output logic [OUT_W-1:0] lane_out
);

    logic [LANE_W-1:0] lane_bits;

    always_comb begin
        lane_bits = LANE_W'(word >> (int'(lane_sel) * LANE_W));
        lane_out  = OUT_W'(lane_ext(EXT_W'(lane_bits), LANE_W, SIGNED != 0));
    end

endmodule

// File: rtl/port_lane_serializer.sv
// Splits each accepted IN_W-bit word into NLANES registered lane beats,
// with per-word beat order and sign/zero extension to OUT_W.
module port_lane_serializer
    import port_lane_pkg::*;
#(
    parameter  int IN_W   = 8,
    parameter  int LANE_W = 4,
    parameter  int OUT_W  = 8,
    parameter  int SIGNED = 0,
    localparam int NLANES = IN_W / LANE_W,
    localparam int IDX_W  = idx_w(NLANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_msb_first,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic [IDX_W-1:0] m_idx,
    output logic             m_last
);

    if (IN_W % LANE_W != 0) begin : g_bad_in_w
        $error("port_lane_serializer: IN_W must be a multiple of LANE_W");
    end
    if (OUT_W < LANE_W) begin : g_bad_out_w
        $error("port_lane_serializer: OUT_W must be at least LANE_W");
    end

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NLANES - 1);

    state_e           state_q, state_d;
    logic [IN_W-1:0]  word_q, word_d;
    logic             msb_first_q, msb_first_d;
    logic [IDX_W-1:0] beat_q, beat_d;
    logic             m_valid_q, m_valid_d;
    logic [OUT_W-1:0] m_data_q, m_data_d;
    logic [IDX_W-1:0] m_idx_q, m_idx_d;
    logic             m_last_q, m_last_d;

    logic             accept, advance, done;
    logic [IN_W-1:0]  ext_word;
    logic             ext_msb;
    logic [IDX_W-1:0] ext_lane;
    logic [OUT_W-1:0] ext_data;

    // A newly accepted word feeds the extractor directly so its first beat
    // lands in the output register on the very next edge.
    lane_extract #(
        .IN_W  (IN_W),
        .LANE_W(LANE_W),
        .OUT_W (OUT_W),
        .SIGNED(SIGNED),
        .IDX_W (IDX_W)
    ) u_lane_extract (
        .word    (ext_word),
        .lane_sel(ext_lane),
        .lane_out(ext_data)
    );

    always_comb begin
        s_ready = 1'b0;
        if (!rst) begin
            s_ready = (state_q == IDLE) || (m_valid_q && m_last_q && m_ready);
        end
        accept  = s_valid && s_ready;
        advance = (state_q == SHIFT) && m_valid_q && m_ready && !m_last_q;
        done    = (state_q == SHIFT) && m_valid_q && m_ready && m_last_q;

        ext_word = accept ? s_data : word_q;
        ext_msb  = accept ? s_msb_first : msb_first_q;
        beat_d   = accept ? '0 : (advance ? beat_q + 1'b1 : beat_q);
        ext_lane = ext_msb ? LAST_BEAT - beat_d : beat_d;

        state_d     = state_q;
        word_d      = word_q;
        msb_first_d = msb_first_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_idx_d     = m_idx_q;
        m_last_d    = m_last_q;

        if (accept) begin
            state_d     = SHIFT;
            word_d      = s_data;
            msb_first_d = s_msb_first;
            m_valid_d   = 1'b1;
            m_data_d    = ext_data;
            m_idx_d     = ext_lane;
            m_last_d    = (beat_d == LAST_BEAT);
        end else if (advance) begin
            m_data_d = ext_data;
            m_idx_d  = ext_lane;
            m_last_d = (beat_d == LAST_BEAT);
        end else if (done) begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            msb_first_q <= 1'b0;
            beat_q      <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_idx_q     <= '0;
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            msb_first_q <= msb_first_d;
            beat_q      <= beat_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_idx_q     <= m_idx_d;
            m_last_q    <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_idx   = m_idx_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_port_lane_serializer.sv
// Bench for port_lane_serializer: four configurations driven by directed and
// random words, checked against an arithmetic model of the lane rules.
module tb_port_lane_serializer;

    logic        clk;
    logic        rst;
    logic        sv  [4];
    logic        sr  [4];
    logic        msb [4];
    logic        mr  [4];
    logic        mv  [4];
    logic        ml  [4];
    logic [7:0]  sd0, sd1, sd3;
    logic [31:0] sd2;
    logic [7:0]  md0, md1, md2;
    logic [15:0] md3;
    logic [0:0]  mi0, mi1, mi3;
    logic [1:0]  mi2;

    int checks = 0;
    int errors = 0;

    port_lane_serializer #(.IN_W(8), .LANE_W(4), .OUT_W(8), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd0),
        .s_msb_first(msb[0]), .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md0),
        .m_idx(mi0), .m_last(ml[0]));
    port_lane_serializer #(.IN_W(8), .LANE_W(4), .OUT_W(8), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd1),
        .s_msb_first(msb[1]), .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md1),
        .m_idx(mi1), .m_last(ml[1]));
    port_lane_serializer #(.IN_W(32), .LANE_W(8), .OUT_W(8), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(sd2),
        .s_msb_first(msb[2]), .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md2),
        .m_idx(mi2), .m_last(ml[2]));
    port_lane_serializer #(.IN_W(8), .LANE_W(8), .OUT_W(16), .SIGNED(1)) u3 (
        .clk(clk), .rst(rst), .s_valid(sv[3]), .s_ready(sr[3]), .s_data(sd3),
        .s_msb_first(msb[3]), .m_valid(mv[3]), .m_ready(mr[3]), .m_data(md3),
        .m_idx(mi3), .m_last(ml[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int in_w(input int u);   return (u == 2) ? 32 : 8; endfunction
    function automatic int lane_w(input int u); return (u >= 2) ? 8 : 4; endfunction
    function automatic int out_w(input int u);  return (u == 3) ? 16 : 8; endfunction
    function automatic bit sgn(input int u);    return (u == 1 || u == 3); endfunction
    function automatic int lanes(input int u);  return in_w(u) / lane_w(u); endfunction

    function automatic int exp_lane(input int u, input int k, input logic m);
        return m ? lanes(u) - 1 - k : k;
    endfunction

    function automatic logic [15:0] exp_data(input int u, input logic [31:0] w,
                                             input int k, input logic m);
        longint v;
        int     lw;
        lw = lane_w(u);
        v  = (longint'(w) >> (exp_lane(u, k, m) * lw)) & ((longint'(1) << lw) - 1);
        if (sgn(u) && v >= (longint'(1) << (lw - 1)))
            v = v + (longint'(1) << out_w(u)) - (longint'(1) << lw);
        return 16'(v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_in(input int u, input logic v, input logic [31:0] d,
                          input logic m, input logic r);
        sv[u]  = v;
        msb[u] = m;
        mr[u]  = r;
        case (u)
            0:       sd0 = d[7:0];
            1:       sd1 = d[7:0];
            2:       sd2 = d;
            default: sd3 = d[7:0];
        endcase
    endtask

    task automatic get_out(input int u, output logic v, output logic [15:0] d,
                           output logic [1:0] i, output logic l, output logic r);
        v = mv[u];
        l = ml[u];
        r = sr[u];
        case (u)
            0:       begin d = {8'h00, md0}; i = {1'b0, mi0}; end
            1:       begin d = {8'h00, md1}; i = {1'b0, mi1}; end
            2:       begin d = {8'h00, md2}; i = mi2;         end
            default: begin d = md3;          i = {1'b0, mi3}; end
        endcase
    endtask

    // One word through unit u; pat[c] is m_ready during beat cycle c (then 1).
    task automatic send_word(input int u, input logic [31:0] w, input logic m,
                             input logic [15:0] pat);
        logic v, l, r, rdy;
        logic [15:0] d;
        logic [1:0]  i;
        int k;
        get_out(u, v, d, i, l, r);
        chk("idle_ready", 64'(r), 64'(1));
        chk("idle_valid", 64'(v), 64'(0));
        set_in(u, 1'b1, w, m, 1'b0);
        @(negedge clk);
        k = 0;
        for (int c = 0; c < 40 && k < lanes(u); c++) begin
            get_out(u, v, d, i, l, r);
            chk("beat_valid", 64'(v), 64'(1));
            chk("beat_data", 64'(d), 64'(exp_data(u, w, k, m)));
            chk("beat_idx", 64'(i), 64'(exp_lane(u, k, m)));
            chk("beat_last", 64'(l), 64'(k == lanes(u) - 1));
            rdy = (c < 16) ? pat[c] : 1'b1;
            set_in(u, 1'b0, $urandom, 1'($urandom), rdy);
            @(negedge clk);
            if (rdy) k++;
        end
        chk("beat_count", 64'(k), 64'(lanes(u)));
        get_out(u, v, d, i, l, r);
        chk("drop_valid", 64'(v), 64'(0));
        set_in(u, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $error("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic v, l, r, m0, m1;
        logic [15:0] d;
        logic [1:0]  i;
        logic [31:0] w0, w1, ww;

        rst = 1'b1;
        for (int u = 0; u < 4; u++) set_in(u, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            get_out(u, v, d, i, l, r);
            chk("rst_valid", 64'(v), 64'(0));
            chk("rst_data", 64'(d), 64'(0));
            chk("rst_idx", 64'(i), 64'(0));
            chk("rst_last", 64'(l), 64'(0));
            chk("rst_ready", 64'(r), 64'(0));
        end
        rst = 1'b0;
        @(negedge clk);

        send_word(0, 32'hA5, 1'b1, 16'hFFFF);
        send_word(1, 32'hA5, 1'b0, 16'hFFFF);
        send_word(3, 32'h80, 1'b0, 16'hFFFF);
        send_word(0, 32'h5A, 1'b0, 16'hFFF9);
        send_word(2, 32'hDEADBEEF, 1'b1, 16'hFFF9);

        // Back-to-back words on the 32-bit unit with continuous valid.
        w0 = 32'h11223344;
        w1 = 32'h55667788;
        m0 = 1'($urandom);
        m1 = 1'($urandom);
        set_in(2, 1'b1, w0, m0, 1'b1);
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            ww = (b < 4) ? w0 : w1;
            get_out(2, v, d, i, l, r);
            chk("b2b_valid", 64'(v), 64'(1));
            chk("b2b_data", 64'(d), 64'(exp_data(2, ww, b % 4, (b < 4) ? m0 : m1)));
            chk("b2b_idx", 64'(i), 64'(exp_lane(2, b % 4, (b < 4) ? m0 : m1)));
            chk("b2b_ready", 64'(r), 64'(b % 4 == 3));
            if (b < 3)       set_in(2, 1'b1, $urandom, 1'($urandom), 1'b1);
            else if (b == 3) set_in(2, 1'b1, w1, m1, 1'b1);
            else             set_in(2, 1'b0, $urandom, 1'($urandom), 1'b1);
            @(negedge clk);
        end
        get_out(2, v, d, i, l, r);
        chk("b2b_drop", 64'(v), 64'(0));
        set_in(2, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset after the first beat of a word, then a clean word.
        set_in(0, 1'b1, 32'hA5, 1'b1, 1'b0);
        @(negedge clk);
        get_out(0, v, d, i, l, r);
        chk("pre_rst_data", 64'(d), 64'(exp_data(0, 32'hA5, 0, 1'b1)));
        set_in(0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        get_out(0, v, d, i, l, r);
        chk("mid_rst_valid", 64'(v), 64'(0));
        chk("mid_rst_ready", 64'(r), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word(0, 32'h3C, 1'b1, 16'hFFFF);

        for (int u = 0; u < 4; u++) begin
            for (int n = 0; n < 8; n++) begin
                send_word(u, $urandom, 1'($urandom), 16'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
